// File: rtl/pcie_us_cfg_mon.sv
`default_nettype none
// ============================================================================
// Module   : pcie_us_cfg_mon
// Purpose  : Periodically sweeps every PF/VF over cfg_mgmt, reading DevCtl and
//            optionally DevCtl2, and publishes per-function DMA settings.
// Revision : 1.0 - initial release
// ============================================================================
module pcie_us_cfg_mon #(
    parameter int          PF_COUNT        = 1,
    parameter int          VF_COUNT        = 0,
    parameter int          VF_OFFSET       = 64,
    parameter int          F_COUNT         = PF_COUNT + VF_COUNT,
    parameter logic [11:0] PCIE_CAP_OFFSET = 12'h0C0,
    parameter int          READ_DEV_CTRL2  = 1,
    parameter int          POLL_INTERVAL   = 256,
    parameter int          TIMEOUT         = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 refresh_i,
    output logic [F_COUNT-1:0]   ext_tag_enable_o,
    output logic [3*F_COUNT-1:0] max_read_request_size_o,
    output logic [3*F_COUNT-1:0] max_payload_size_o,
    output logic [F_COUNT-1:0]   relaxed_ordering_enable_o,
    output logic [F_COUNT-1:0]   ten_bit_tag_enable_o,
    output logic [F_COUNT-1:0]   cfg_valid_o,
    output logic                 sweep_done_o,
    output logic                 timeout_error_o,
    output logic [9:0]           cfg_mgmt_addr_o,
    output logic [7:0]           cfg_mgmt_function_number_o,
    output logic                 cfg_mgmt_write_o,
    output logic [31:0]          cfg_mgmt_write_data_o,
    output logic [3:0]           cfg_mgmt_byte_enable_o,
    output logic                 cfg_mgmt_read_o,
    input  logic [31:0]          cfg_mgmt_read_data_i,
    input  logic                 cfg_mgmt_read_write_done_i
);

    localparam int               IDX_W         = (F_COUNT > 1) ? $clog2(F_COUNT) : 1;
    localparam logic [9:0]       C_DC_ADDR     = 10'((PCIE_CAP_OFFSET + 12'h008) >> 2);
    localparam logic [9:0]       C_DC2_ADDR    = 10'((PCIE_CAP_OFFSET + 12'h028) >> 2);
    localparam logic [15:0]      C_POLL_RELOAD = 16'(POLL_INTERVAL - 1);
    localparam logic [15:0]      C_WAIT_MAX    = 16'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] C_LAST_IDX    = IDX_W'(F_COUNT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RD_DC  = 2'd1,
        S_RD_DC2 = 2'd2,
        S_NEXT   = 2'd3
    } state_t;

    state_t           state_q;
    logic [15:0]      poll_q;
    logic [15:0]      wait_q;
    logic [IDX_W-1:0] idx_q;
    logic             read_q;
    logic [9:0]       addr_q;
    logic [7:0]       fn_q;
    logic             sweep_done_q;
    logic             tmo_q;
    logic             pend_q;

    logic [7:0] w_fn;
    logic       w_done;
    logic       w_dc_wr;
    logic       w_dc2_wr;
    logic       w_valid_set;
    logic       w_unused_rd;

    // PFs map straight through; VFs sit at VF_OFFSET upward with 8-bit wrap.
    always_comb begin
        w_fn = 8'(idx_q);
        if (int'(idx_q) >= PF_COUNT) begin
            w_fn = 8'(VF_OFFSET + int'(idx_q) - PF_COUNT);
        end
    end

    assign w_done      = read_q && cfg_mgmt_read_write_done_i;
    assign w_dc_wr     = (state_q == S_RD_DC) && w_done;
    assign w_dc2_wr    = (READ_DEV_CTRL2 != 0) && (state_q == S_RD_DC2) && w_done;
    assign w_valid_set = (READ_DEV_CTRL2 != 0) ? w_dc2_wr : w_dc_wr;
    assign w_unused_rd = ^{cfg_mgmt_read_data_i[31:15], cfg_mgmt_read_data_i[11:9],
                           cfg_mgmt_read_data_i[3:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            poll_q       <= C_POLL_RELOAD;
            wait_q       <= '0;
            idx_q        <= '0;
            read_q       <= 1'b0;
            addr_q       <= '0;
            fn_q         <= '0;
            sweep_done_q <= 1'b0;
            tmo_q        <= 1'b0;
            pend_q       <= 1'b0;
        end else begin
            sweep_done_q <= 1'b0;
            tmo_q        <= 1'b0;
            if (refresh_i && (state_q != S_IDLE)) begin
                pend_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if ((poll_q == '0) || refresh_i || pend_q) begin
                        state_q <= S_RD_DC;
                        idx_q   <= '0;
                        pend_q  <= 1'b0;
                    end else begin
                        poll_q <= poll_q - 16'd1;
                    end
                end
                S_RD_DC, S_RD_DC2: begin
                    // First cycle in a read state is the idle gap; the request goes out at its end.
                    if (!read_q) begin
                        read_q <= 1'b1;
                        addr_q <= (state_q == S_RD_DC) ? C_DC_ADDR : C_DC2_ADDR;
                        fn_q   <= w_fn;
                        wait_q <= '0;
                    end else if (cfg_mgmt_read_write_done_i) begin
                        read_q  <= 1'b0;
                        state_q <= ((state_q == S_RD_DC) && (READ_DEV_CTRL2 != 0)) ? S_RD_DC2 : S_NEXT;
                    end else if (wait_q == C_WAIT_MAX) begin
                        read_q  <= 1'b0;
                        tmo_q   <= 1'b1;
                        state_q <= S_NEXT;
                    end else begin
                        wait_q <= wait_q + 16'd1;
                    end
                end
                S_NEXT: begin
                    if (idx_q == C_LAST_IDX) begin
                        idx_q        <= '0;
                        sweep_done_q <= 1'b1;
                        poll_q       <= C_POLL_RELOAD;
                        state_q      <= S_IDLE;
                    end else begin
                        idx_q   <= idx_q + IDX_W'(1);
                        state_q <= S_RD_DC;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    read_q  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar gi = 0; gi < F_COUNT; gi++) begin : g_func
        logic       w_sel;
        logic       ext_q;
        logic [2:0] mrrs_q;
        logic [2:0] mps_q;
        logic       ro_q;
        logic       ten_q;
        logic       valid_q;

        assign w_sel = (idx_q == IDX_W'(gi));

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                ext_q   <= 1'b0;
                mrrs_q  <= 3'd0;
                mps_q   <= 3'd0;
                ro_q    <= 1'b0;
                ten_q   <= 1'b0;
                valid_q <= 1'b0;
            end else begin
                if (w_sel && w_dc_wr) begin
                    ext_q  <= cfg_mgmt_read_data_i[8];
                    mrrs_q <= cfg_mgmt_read_data_i[14:12];
                    mps_q  <= cfg_mgmt_read_data_i[7:5];
                    ro_q   <= cfg_mgmt_read_data_i[4];
                end
                if (w_sel && w_dc2_wr) begin
                    ten_q <= cfg_mgmt_read_data_i[12];
                end
                if (w_sel && w_valid_set) begin
                    valid_q <= 1'b1;
                end
            end
        end

        assign ext_tag_enable_o[gi]            = ext_q;
        assign max_read_request_size_o[3*gi+:3] = mrrs_q;
        assign max_payload_size_o[3*gi+:3]      = mps_q;
        assign relaxed_ordering_enable_o[gi]   = ro_q;
        assign ten_bit_tag_enable_o[gi]        = ten_q;
        assign cfg_valid_o[gi]                 = valid_q;
    end

    assign sweep_done_o               = sweep_done_q;
    assign timeout_error_o            = tmo_q;
    assign cfg_mgmt_addr_o            = addr_q;
    assign cfg_mgmt_function_number_o = fn_q;
    assign cfg_mgmt_read_o            = read_q;
    assign cfg_mgmt_write_o           = 1'b0;
    assign cfg_mgmt_write_data_o      = 32'h0000_0000;
    assign cfg_mgmt_byte_enable_o     = 4'hF;

endmodule
`default_nettype wire

// File: tb/tb_pcie_us_cfg_mon.sv
`default_nettype none
// ============================================================================
// Module   : tb_pcie_us_cfg_mon
// Purpose  : Directed bench for pcie_us_cfg_mon with a cfg_mgmt responder model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pcie_us_cfg_mon;

    localparam int P = 40;
    localparam int T = 16;
    localparam int F = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           refresh = 1'b0;
    logic [F-1:0]   ext_tag, ro, ten, valid;
    logic [3*F-1:0] mrrs, mps;
    logic           sweep_done, tmo_err;
    logic [9:0]     addr;
    logic [7:0]     fn;
    logic           wr;
    logic [31:0]    wr_data;
    logic [3:0]     be;
    logic           rd;
    logic [31:0]    rd_data = 32'hFFFF_FFFF;
    logic           rw_done = 1'b0;

    int tests = 0;
    int fails = 0;

    pcie_us_cfg_mon #(
        .PF_COUNT(2), .VF_COUNT(2), .VF_OFFSET(64),
        .READ_DEV_CTRL2(1), .POLL_INTERVAL(P), .TIMEOUT(T)
    ) dut (
        .clk(clk), .rst(rst), .refresh_i(refresh),
        .ext_tag_enable_o(ext_tag), .max_read_request_size_o(mrrs),
        .max_payload_size_o(mps), .relaxed_ordering_enable_o(ro),
        .ten_bit_tag_enable_o(ten), .cfg_valid_o(valid),
        .sweep_done_o(sweep_done), .timeout_error_o(tmo_err),
        .cfg_mgmt_addr_o(addr), .cfg_mgmt_function_number_o(fn),
        .cfg_mgmt_write_o(wr), .cfg_mgmt_write_data_o(wr_data),
        .cfg_mgmt_byte_enable_o(be), .cfg_mgmt_read_o(rd),
        .cfg_mgmt_read_data_i(rd_data), .cfg_mgmt_read_write_done_i(rw_done)
    );

    always #5 clk = ~clk;

    // Responder: completes each read 3 cycles after it is raised, unless the function is muted.
    logic       mute_en = 1'b0;
    logic [7:0] mute_fn = 8'd0;
    logic       zero_dc = 1'b0;
    int         rcnt = 0;

    function automatic logic [31:0] model(input logic [7:0] f, input logic [9:0] a, input logic z);
        if (a == 10'h032) begin
            if (z) return 32'h0;
            case (f)
                8'd0:    return 32'h0000_2150;
                8'd1:    return 32'h0000_7010;
                8'd64:   return 32'h0000_5030;
                8'd65:   return 32'h0000_41E0;
                default: return 32'hDEAD_BEEF;
            endcase
        end else if (a == 10'h03A) begin
            case (f)
                8'd64:   return 32'h0000_0000;
                8'd0, 8'd1, 8'd65: return 32'h0000_1000;
                default: return 32'hDEAD_BEEF;
            endcase
        end
        return 32'hDEAD_BEEF;
    endfunction

    always @(posedge clk) begin
        #1;
        rw_done = 1'b0;
        rd_data = 32'hFFFF_FFFF;
        if (rst || !rd || (mute_en && fn == mute_fn)) begin
            rcnt = 0;
        end else begin
            rcnt++;
            if (rcnt == 3) begin
                rw_done = 1'b1;
                rd_data = model(fn, addr, zero_dc);
                rcnt    = 0;
            end
        end
    end

    // Monitor: logs each request and how long read stayed high; counts strobes.
    logic [7:0] q_fn[$];
    logic [9:0] q_addr[$];
    int         q_len[$];
    int         n_tmo = 0;
    int         n_done = 0;
    logic       prev_rd = 1'b0;
    int         hi_len = 0;

    always @(posedge clk) begin
        #1;
        if (rst) begin
            prev_rd = 1'b0;
            hi_len  = 0;
        end else begin
            if (rd && !prev_rd) begin
                q_fn.push_back(fn);
                q_addr.push_back(addr);
                hi_len = 0;
            end
            if (rd) hi_len++;
            else if (prev_rd) q_len.push_back(hi_len);
            if (tmo_err) n_tmo++;
            if (sweep_done) n_done++;
            prev_rd = rd;
        end
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_read(input int limit, output int n);
        n = 0;
        while (!rd && n < limit) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_sweep(input int base, input string tag);
        int n = 0;
        while (n_done <= base && n < 2000) begin
            tick();
            n++;
        end
        check(tag, 64'(n_done > base), 64'd1);
    endtask

    task automatic check_fields(input string tag, input logic [3:0] e_ext, input logic [11:0] e_mrrs,
                                input logic [11:0] e_mps, input logic [3:0] e_ro,
                                input logic [3:0] e_ten, input logic [3:0] e_valid);
        check({tag, "_ext"},   64'(ext_tag), 64'(e_ext));
        check({tag, "_mrrs"},  64'(mrrs),    64'(e_mrrs));
        check({tag, "_mps"},   64'(mps),     64'(e_mps));
        check({tag, "_ro"},    64'(ro),      64'(e_ro));
        check({tag, "_ten"},   64'(ten),     64'(e_ten));
        check({tag, "_valid"}, 64'(valid),   64'(e_valid));
    endtask

    logic [7:0] exp_fn   [0:6] = '{8'd0, 8'd0, 8'd1, 8'd64, 8'd64, 8'd65, 8'd65};
    logic [9:0] exp_addr [0:6] = '{10'h032, 10'h03A, 10'h032, 10'h032, 10'h03A, 10'h032, 10'h03A};

    initial begin
        int n;
        int base;
        int highs;
        mute_en = 1'b1;
        mute_fn = 8'd1;
        repeat (3) tick();

        check("rst_read",  64'(rd),         64'd0);
        check("rst_addr",  64'(addr),       64'd0);
        check("rst_fn",    64'(fn),         64'd0);
        check("rst_be",    64'(be),         64'hF);
        check("rst_write", 64'({wr, wr_data}), 64'd0);
        check("rst_done",  64'({sweep_done, tmo_err}), 64'd0);
        check_fields("rst", 4'h0, 12'h0, 12'h0, 4'h0, 4'h0, 4'h0);

        @(posedge clk);
        #2 rst = 1'b0;
        wait_read(P + 10, n);
        check("first_lat_in_range", 64'(n >= P && n <= P + 2), 64'd1);

        // Sweep 1: function 1 never answers.
        wait_sweep(0, "sweep1_done");
        check("sweep1_nreq", 64'(q_fn.size()), 64'd7);
        for (int i = 0; i < 7 && i < q_fn.size(); i++) begin
            check($sformatf("sweep1_fn%0d", i),   64'(q_fn[i]),   64'(exp_fn[i]));
            check($sformatf("sweep1_addr%0d", i), 64'(q_addr[i]), 64'(exp_addr[i]));
        end
        check("sweep1_len_ok",  64'(q_len.size() > 2 ? q_len[0] : -1), 64'd3);
        check("sweep1_len_tmo", 64'(q_len.size() > 2 ? q_len[2] : -1), 64'(T));
        check("sweep1_ntmo",    64'(n_tmo),  64'd1);
        check("sweep1_ndone",   64'(n_done), 64'd1);
        check_fields("sweep1", 4'b1001, {3'd4, 3'd5, 3'd0, 3'd2}, {3'd7, 3'd1, 3'd0, 3'd2},
                     4'b0101, 4'b1001, 4'b1101);

        // Sweep 2: refresh 10 cycles into IDLE.
        mute_en = 1'b0;
        repeat (10) tick();
        check("idle_no_read", 64'(rd), 64'd0);
        refresh = 1'b1;
        tick();
        refresh = 1'b0;
        wait_read(10, n);
        check("refresh_lat", 64'(rd == 1'b1 && n + 1 <= 2), 64'd1);
        wait_sweep(1, "sweep2_done");
        check_fields("sweep2", 4'b1001, {3'd4, 3'd5, 3'd7, 3'd2}, {3'd7, 3'd1, 3'd0, 3'd2},
                     4'b0111, 4'b1011, 4'b1111);

        // Sweep 3 with refresh mid-sweep; sweep 4 must follow at once with DevCtl zeroed.
        tick();
        refresh = 1'b1;
        tick();
        refresh = 1'b0;
        base = q_len.size();
        n = 0;
        while (q_len.size() == base && n < 100) begin
            tick();
            n++;
        end
        refresh = 1'b1;
        tick();
        refresh = 1'b0;
        wait_sweep(2, "sweep3_done");
        zero_dc = 1'b1;
        wait_read(10, n);
        check("pend_restart", 64'(rd == 1'b1 && n <= 3), 64'd1);
        wait_sweep(3, "sweep4_done");
        check_fields("sweep4", 4'b0000, 12'h0, 12'h0, 4'b0000, 4'b1011, 4'b1111);
        highs = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (rd) highs++;
        end
        check("no_extra_sweep", 64'(highs), 64'd0);
        check("ntmo_total",     64'(n_tmo), 64'd1);

        // Reset while a read is outstanding.
        wait_read(P + 10, n);
        check("read_before_rst", 64'(rd), 64'd1);
        #1 rst = 1'b1;
        #1;
        check("arst_read", 64'(rd),   64'd0);
        check("arst_addr", 64'(addr), 64'd0);
        check_fields("arst", 4'h0, 12'h0, 12'h0, 4'h0, 4'h0, 4'h0);
        tick();
        tick();
        @(posedge clk);
        #2 rst = 1'b0;
        wait_read(P + 10, n);
        check("restart_lat_in_range", 64'(n >= P && n <= P + 2), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
